// File: rtl/adc_frame_reader_if.sv
// Capture-control, buffer-read and output-stream signals of adc_frame_reader.
// master = the reader; slave = writer/buffer/downstream side.
interface adc_frame_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              run;
  logic              cap_start;
  logic              cap_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    input  run, cap_done, rd_data, out_ready,
    output cap_start, r_addr, out_data, out_valid, out_last, busy
  );

  modport slave (
    output run, cap_done, rd_data, out_ready,
    input  cap_start, r_addr, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/adc_frame_reader.sv
// Arms the ADC writer, waits for a full buffer, streams it out in address order, re-arms.
// ADC_FRAME_HDR_EN: prefix each frame with {16'hA5C3, frame_cnt} and keep a frame counter.
module adc_frame_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                n_reset,
  adc_frame_reader_if.master  bus
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_FULL, S_DRAIN, S_RELEASE} state_t;
  state_t r_state, w_next;

  logic [RD_LAT-1:0] r_vld_pipe, r_last_pipe;
  logic              r_rd_done;
  logic [DATA_W:0]   r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_ret, w_hdr_push, w_push, w_pop, w_issue, w_frame_end, w_cap_full;
  logic [DATA_W:0]   w_push_word;
  int                w_pend;

  assign w_cap_full  = (r_state == S_WAIT_FULL) && bus.cap_done;
  assign w_ret       = r_vld_pipe[RD_LAT-1];
  assign w_push      = w_ret | w_hdr_push;
  assign w_pop       = (r_count != '0) && bus.out_ready;
  assign w_frame_end = (r_state == S_DRAIN) && w_pop && r_fifo[r_rptr][DATA_W];

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_fifo[r_rptr][DATA_W-1:0];
  assign bus.out_last  = bus.out_valid & r_fifo[r_rptr][DATA_W];

`ifdef ADC_FRAME_HDR_EN
  logic        r_hdr_pend;
  logic [15:0] r_frame_cnt;

  // Header is pushed in the first DRAIN cycle; no read data can return that early.
  assign w_hdr_push  = r_hdr_pend;
  assign w_push_word = w_ret ? {r_last_pipe[RD_LAT-1], bus.rd_data}
                             : {1'b0, DATA_W'({16'hA5C3, r_frame_cnt})};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_hdr_pend  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_hdr_pend <= w_cap_full;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`else
  assign w_hdr_push  = 1'b0;
  assign w_push_word = {r_last_pipe[RD_LAT-1], bus.rd_data};
`endif

  // The word leaving this cycle frees its slot, so a full FIFO still streams 1 word/cycle.
  always_comb begin
    w_pend  = int'(r_count) + $countones(r_vld_pipe) + int'(w_hdr_push) - int'(w_pop);
    w_issue = (r_state == S_DRAIN) && !r_rd_done && (w_pend < DEPTH);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.cap_start = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:      if (bus.run) w_next = S_ARM;
      S_ARM: begin
        bus.cap_start = 1'b1;
        w_next        = S_WAIT_FULL;
      end
      S_WAIT_FULL: begin
        bus.cap_start = 1'b1;
        if (bus.cap_done) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.cap_start = 1'b1;
        if (w_frame_end) w_next = S_RELEASE;
      end
      S_RELEASE:   if (!bus.cap_done) w_next = bus.run ? S_ARM : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Read issue: address counter parks on the last word; tags follow reads through the latency.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.r_addr  <= '0;
      r_rd_done   <= 1'b0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      r_vld_pipe[0]  <= w_issue;
      r_last_pipe[0] <= w_issue && (bus.r_addr == LAST_ADDR);
      if (w_cap_full) begin
        bus.r_addr <= '0;
        r_rd_done  <= 1'b0;
      end else if (w_issue) begin
        if (bus.r_addr == LAST_ADDR) r_rd_done  <= 1'b1;
        else                         bus.r_addr <= bus.r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_push_word;
        r_wptr         <= (r_wptr == PTR_MAX) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= (r_rptr == PTR_MAX) ? '0 : r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: tb/tb_adc_frame_reader.sv
// Directed bench for adc_frame_reader (RD_LAT=2) with writer and buffer models;
// the stream model checks every presented word against address order.
module tb_adc_frame_reader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int NW     = 1 << ADDR_W;
  localparam int WR_DLY = 600;
`ifdef ADC_FRAME_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int FW = NW + int'(HDR);

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  adc_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) tb_if ();

  adc_frame_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (tb_if.master)
  );

  function automatic logic [31:0] word(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {4{b}};
  endfunction

  // buffer: data valid RD_LAT cycles after r_addr
  logic [31:0] rd_p [RD_LAT];
  always_ff @(posedge clk) begin
    rd_p[0] <= word(int'(tb_if.r_addr));
    for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
  end
  assign tb_if.rd_data = rd_p[RD_LAT-1];

  // writer: doneWriting WR_DLY cycles after start, cleared when start drops
  int wr_cnt;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_cnt         <= 0;
      tb_if.cap_done <= 1'b0;
    end else if (!tb_if.cap_start) begin
      wr_cnt         <= 0;
      tb_if.cap_done <= 1'b0;
    end else if (wr_cnt == WR_DLY) tb_if.cap_done <= 1'b1;
    else wr_cnt <= wr_cnt + 1;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_idx  = 0;
  bit          hdr_pend = HDR;
  logic [15:0] exp_fcnt = '0;
  int          frame_words = 0;
  int          last_words  = 0;
  bit          frame_done  = 1'b0;
  bit          cd_rise     = 1'b0;
  bit          prev_cd     = 1'b0;

  typedef struct {
    int mode;
    int exp_lat;
    int exp_span;
    int exp_words;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive ready at negedge, check the presented word, advance on transfer.
  task automatic tick(input logic rdy);
    logic [31:0] ew;
    logic        el;
    @(negedge clk);
    tb_if.out_ready = rdy;
    cd_rise = tb_if.cap_done && !prev_cd;
    prev_cd = tb_if.cap_done;
    if (tb_if.out_valid) begin
      if (hdr_pend) begin
        ew = {16'hA5C3, exp_fcnt};
        el = 1'b0;
      end else begin
        ew = word(exp_idx);
        el = (exp_idx == NW - 1);
      end
      chk("out_data", tb_if.out_data, ew);
      chk("out_last", 32'(tb_if.out_last), 32'(el));
      if (rdy) begin
        frame_words++;
        if (hdr_pend) hdr_pend = 1'b0;
        else if (el) begin
          frame_done  = 1'b1;
          last_words  = frame_words;
          frame_words = 0;
          exp_idx     = 0;
          hdr_pend    = HDR;
          exp_fcnt    = exp_fcnt + 16'd1;
        end else exp_idx++;
      end
    end
  endtask

  // Run until a frame completes; lat = edges from DRAIN entry to first out_valid.
  task automatic drain(input int mode, output int lat, output int span);
    int cyc;
    bit seen;
    lat = -1; span = -1; cyc = 0; seen = 1'b0;
    frame_done = 1'b0;
    for (int i = 0; i < 4000 && !frame_done; i++) begin
      tick(mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      if (cd_rise) begin
        seen = 1'b1;
        cyc  = -1;
      end else if (seen) cyc++;
      if (seen && lat < 0 && tb_if.out_valid) lat = cyc;
      if (frame_done && lat >= 0) span = cyc - lat;
    end
    chk("frame_complete", 32'(frame_done), 32'd1);
  endtask

  initial begin
    int lat, span;
    bit ok;
    n_reset         = 1'b0;
    tb_if.run       = 1'b0;
    tb_if.out_ready = 1'b0;
    tbl[0] = '{0, HDR ? 1 : RD_LAT + 1, HDR ? NW + 1 : NW - 1, FW};
    tbl[1] = '{1, HDR ? 1 : RD_LAT + 1, -1, FW};
    tbl[2] = '{0, HDR ? 1 : RD_LAT + 1, HDR ? NW + 1 : NW - 1, FW};

    repeat (3) tick(1'b0);
    chk("rst_cap_start", 32'(tb_if.cap_start), 32'd0);
    chk("rst_busy",      32'(tb_if.busy),      32'd0);
    chk("rst_out_valid", 32'(tb_if.out_valid), 32'd0);
    chk("rst_out_last",  32'(tb_if.out_last),  32'd0);
    chk("rst_r_addr",    32'(tb_if.r_addr),    32'd0);
    chk("rst_out_data",  tb_if.out_data,       32'd0);
    n_reset   = 1'b1;
    tb_if.run = 1'b1;

    // back-to-back frames with run held high
    for (int v = 0; v < 3; v++) begin
      drain(tbl[v].mode, lat, span);
      chk("latency", 32'(lat), 32'(tbl[v].exp_lat));
      if (tbl[v].exp_span >= 0) chk("throughput_span", 32'(span), 32'(tbl[v].exp_span));
      chk("frame_words", 32'(last_words), 32'(tbl[v].exp_words));
      ok = 1'b0;
      for (int k = 0; k < 6 && !ok; k++) begin
        tick(1'b1);
        if (!tb_if.cap_start) ok = 1'b1;
      end
      chk("cap_start_fall", 32'(ok), 32'd1);
      chk("busy_in_release", 32'(tb_if.busy), 32'd1);
      ok = 1'b0;
      for (int k = 0; k < 6 && !ok; k++) begin
        tick(1'b1);
        if (tb_if.cap_start) ok = 1'b1;
      end
      chk("rearm", 32'(ok), 32'd1);
    end

    // stall 20 cycles from DRAIN entry, then resume; run dropped mid-frame
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      tick(1'b1);
      if (cd_rise) ok = 1'b1;
    end
    chk("cap_done_seen", 32'(ok), 32'd1);
    repeat (20) tick(1'b0);
    chk("stall_r_addr",    32'(tb_if.r_addr),    32'(RD_LAT + 1 - int'(HDR)));
    chk("stall_out_valid", 32'(tb_if.out_valid), 32'd1);
    chk("stall_out_data",  tb_if.out_data, HDR ? {16'hA5C3, exp_fcnt} : word(0));
    tb_if.run = 1'b0;
    drain(0, lat, span);
    chk("stall_frame_words", 32'(last_words), 32'(FW));
    repeat (4) tick(1'b1);
    chk("idle_busy",      32'(tb_if.busy),      32'd0);
    chk("idle_cap_start", 32'(tb_if.cap_start), 32'd0);

    // single-cycle run pulse: exactly one frame
    tb_if.run = 1'b1;
    tick(1'b1);
    tb_if.run = 1'b0;
    drain(0, lat, span);
    chk("pulse_latency", 32'(lat), 32'(HDR ? 1 : RD_LAT + 1));
    chk("pulse_words",   32'(last_words), 32'(FW));
    repeat (4) tick(1'b1);
    chk("pulse_busy",      32'(tb_if.busy),      32'd0);
    repeat (40) tick(1'b1);
    chk("pulse_no_rearm",  32'(tb_if.cap_start), 32'd0);

    // reset around word 200 of a drain, then a fresh frame from address 0
    tb_if.run = 1'b1;
    frame_done = 1'b0;
    for (int k = 0; k < 3000 && frame_words < 200; k++) tick(1'b1);
    chk("reached_word_200", 32'(frame_words >= 200), 32'd1);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_cap_start", 32'(tb_if.cap_start), 32'd0);
    chk("arst_busy",      32'(tb_if.busy),      32'd0);
    chk("arst_out_valid", 32'(tb_if.out_valid), 32'd0);
    chk("arst_out_last",  32'(tb_if.out_last),  32'd0);
    chk("arst_r_addr",    32'(tb_if.r_addr),    32'd0);
    chk("arst_out_data",  tb_if.out_data,       32'd0);
    exp_idx = 0; hdr_pend = HDR; exp_fcnt = '0; frame_words = 0;
    repeat (3) tick(1'b1);
    n_reset = 1'b1;
    drain(0, lat, span);
    chk("post_rst_latency", 32'(lat), 32'(HDR ? 1 : RD_LAT + 1));
    chk("post_rst_words",   32'(last_words), 32'(FW));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
